fetch_queue: RTL

Instruction fetch front-end between a variable-latency instruction memory and the IF/ID pipeline register of the 16-bit pipelined CPU. Owns the fetch PC and issues in-order memory requests under a credit limit. Buffers returned instructions with their PCs in a small FIFO that the decode side drains. Handles jump redirects by discarding queued and in-flight fetches, and stops fetching on halt.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: default datapath
// width, the buffered {pc, instr} entry and the PC the core fetches from after reset.
package fetch_pkg;

  localparam int FETCH_WIDTH = 16;

  localparam logic [FETCH_WIDTH-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic ring-buffer FIFO with wrap-around pointers, occupancy count,
// synchronous flush and a combinational head (zero when empty).
module fetch_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  // Popping an empty FIFO is a no-op; the caller never has to guard it.
  assign do_pop = pop && (count != '0);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues in-order memory
// requests under a credit limit, buffers returned instructions for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH   = FETCH_WIDTH,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_instr,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  input  logic             deq,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  output logic             proto_err
);

  localparam int BCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } buf_entry_t;

  logic [WIDTH-1:0] fetch_pc;
  logic [OCW-1:0]   drop_cnt;
  logic [OCW-1:0]   outstanding;
  logic [BCW-1:0]   buf_count;
  logic [WIDTH-1:0] rsp_pc;
  buf_entry_t       push_entry;
  buf_entry_t       head_entry;
  logic             has_credit;
  logic             req_fire;
  logic             rsp_accept;
  logic             rsp_keep;

  // Buffer slots are reserved at issue time, so a returning response always
  // finds room and the buffer never needs a full check.
  assign has_credit    = (int'(buf_count) + int'(outstanding) < DEPTH) &&
                         (int'(outstanding) < MAX_OUT);
  assign mem_req_valid = reset && !halt && !redirect && has_credit;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_accept = mem_rsp_valid && (outstanding != '0);
  assign rsp_keep   = rsp_accept && (drop_cnt == '0) && !redirect;

  assign push_entry = '{pc: rsp_pc, instr: mem_rsp_instr};

  // In-flight queue: the PC of each accepted request, matched to responses in order.
  fetch_fifo #(
    .DW    (WIDTH),
    .DEPTH (MAX_OUT)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_accept),
    .flush     (1'b0),
    .head      (rsp_pc),
    .count     (outstanding)
  );

  // Instruction buffer; a redirect flush overrides any push or deq that cycle.
  fetch_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (deq),
    .flush     (redirect),
    .head      (head_entry),
    .count     (buf_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= WIDTH'(RESET_PC);
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        // Everything still in flight is stale; one returning now is dropped directly.
        drop_cnt <= outstanding - OCW'(rsp_accept);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WIDTH'(1);
        if (rsp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
      end
      if (mem_rsp_valid && (outstanding == '0)) proto_err <= 1'b1;
    end
  end

  assign if_valid = (buf_count != '0);
  assign if_pc    = head_entry.pc;
  assign if_instr = head_entry.instr;

endmodule
